// File: rtl/sig_dump_reader.sv
// sig_dump_reader: snoops core stores for a signature window and a halt, then streams data memory out.
// Define SIGDUMP_CSUM_EN to append an XOR checksum word after the data words.
module sig_dump_reader #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [AW-1:0] CFG_BASE = 32'h00000F10,
  parameter logic [AW-1:0] HALT_ADDR = 32'hCAFEBEEF,
  parameter int MAX_WORDS = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_en,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_rd_data,
  output logic          sig_valid,
  output logic [DW-1:0] sig_data,
  output logic          sig_last,
  input  logic          sig_ready,
  output logic          busy,
  output logic          done
);
  localparam int NW = $clog2(MAX_WORDS + 1);
  typedef enum logic [2:0] {IDLE, RD, WAIT, SEND, DONE} state_t;
  state_t state;
  logic [AW-1:0] sig_begin, sig_end, ptr, span, words, st_word;
  logic [NW-1:0] n, n_init;
  logic cfg_b, cfg_e, halt;
`ifdef SIGDUMP_CSUM_EN
  logic [DW-1:0] csum;
  logic csum_sent;
`endif
  always_comb begin
    span = sig_end - sig_begin;
    words = span >> 2;
    n_init = (sig_end <= sig_begin) ? '0 : (words > AW'(MAX_WORDS)) ? NW'(MAX_WORDS) : NW'(words);
  end
  assign st_word = AW'(st_data & ~DW'(3));
  assign cfg_b = st_en && st_addr == CFG_BASE;
  assign cfg_e = st_en && st_addr == CFG_BASE + AW'(4);
  assign halt = st_en && st_addr == HALT_ADDR;
  assign busy = state != IDLE;
  assign mem_rd_addr = ptr;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sig_begin <= '0;
      sig_end <= '0;
      ptr <= '0;
      n <= '0;
      mem_rd_en <= 1'b0;
      sig_valid <= 1'b0;
      sig_data <= '0;
      sig_last <= 1'b0;
      done <= 1'b0;
`ifdef SIGDUMP_CSUM_EN
      csum <= '0;
      csum_sent <= 1'b0;
`endif
    end else begin
      mem_rd_en <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_b) sig_begin <= st_word;
          if (cfg_e) sig_end <= st_word;
          if (halt) begin
            ptr <= sig_begin;
            n <= n_init;
            mem_rd_en <= n_init != '0;
`ifdef SIGDUMP_CSUM_EN
            // An empty window still emits a zero checksum word
            csum <= '0;
            csum_sent <= n_init == '0;
            sig_data <= '0;
            sig_valid <= n_init == '0;
            sig_last <= n_init == '0;
            state <= (n_init == '0) ? SEND : RD;
`else
            state <= (n_init == '0) ? DONE : RD;
`endif
          end
        end
        RD: state <= WAIT;
        WAIT: begin
          sig_data <= mem_rd_data;
          sig_valid <= 1'b1;
`ifdef SIGDUMP_CSUM_EN
          sig_last <= 1'b0;
`else
          sig_last <= n == NW'(1);
`endif
          state <= SEND;
        end
        SEND: if (sig_ready) begin
          sig_valid <= 1'b0;
          sig_last <= 1'b0;
`ifdef SIGDUMP_CSUM_EN
          if (csum_sent) state <= DONE;
          else begin
            ptr <= ptr + AW'(4);
            n <= n - NW'(1);
            csum <= csum ^ sig_data;
            if (n == NW'(1)) begin
              sig_valid <= 1'b1;
              sig_last <= 1'b1;
              sig_data <= csum ^ sig_data;
              csum_sent <= 1'b1;
            end else begin
              state <= RD;
              mem_rd_en <= 1'b1;
            end
          end
`else
          ptr <= ptr + AW'(4);
          n <= n - NW'(1);
          mem_rd_en <= n != NW'(1);
          state <= (n == NW'(1)) ? DONE : RD;
`endif
        end
        DONE: begin
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sig_dump_reader.sv
// tb_sig_dump_reader: scoreboard bench; directed stores queue expected words, a negedge monitor checks the stream.
module tb_sig_dump_reader;
  localparam logic [31:0] CFG = 32'h00000F10;
  localparam logic [31:0] HALT = 32'hCAFEBEEF;
  localparam logic [31:0] A = 32'hA5A50001;
  localparam logic [31:0] B = 32'h5A5A0002;
  localparam logic [31:0] C = 32'h0F0F0003;
  localparam logic [31:0] CS_ABC = 32'hF0F00000;
`ifdef SIGDUMP_CSUM_EN
  localparam int CAPW = 4097;
`else
  localparam int CAPW = 4096;
`endif
  logic clk = 0, rst = 0, st_en = 0, sig_ready = 1;
  logic [31:0] st_addr = 0, st_data = 0, mem_rd_data = 0;
  logic mem_rd_en, sig_valid, sig_last, busy, done;
  logic [31:0] mem_rd_addr, sig_data;
  logic [31:0] mem [256];
  logic [32:0] q [$];
  logic [32:0] e;
  logic cnt_mode = 0, tog = 0, hold_v = 0, hold_l = 0, prev_done = 0;
  logic [31:0] hold_d = 0;
  int checks = 0, failures = 0, done_seen = 0, cnt_words = 0, last_at = 0;

  sig_dump_reader dut (
    .clk(clk), .rst(rst), .st_en(st_en), .st_addr(st_addr), .st_data(st_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .sig_valid(sig_valid), .sig_data(sig_data), .sig_last(sig_last), .sig_ready(sig_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[8'(mem_rd_addr >> 2)];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    st_en = 1; st_addr = a; st_data = d;
    @(posedge clk); #1;
    st_en = 0;
  endtask

  task automatic cfg(input logic [31:0] b, input logic [31:0] en);
    store(CFG, b);
    store(CFG + 4, en);
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    q.push_back({l, d});
  endtask

  task automatic push3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] cs);
`ifdef SIGDUMP_CSUM_EN
    push(a, 0); push(b, 0); push(c, 0); push(cs, 1);
`else
    push(a, 0); push(b, 0); push(c, 1);
    if (cs === 32'hx) $display("unused checksum");
`endif
  endtask

  task automatic wait_done(input int bound, input string name);
    int d0;
    d0 = done_seen;
    for (int i = 0; i < bound && done_seen == d0; i++) @(posedge clk);
    #1;
    chk(name, 64'(done_seen > d0), 1);
  endtask

  task automatic empty_dump(input string name);
`ifdef SIGDUMP_CSUM_EN
    push(0, 1);
    store(HALT, 0);
    wait_done(20, name);
`else
    store(HALT, 0);
    chk({name, "_busy"}, busy, 1);
    chk({name, "_done_early"}, done, 0);
    @(posedge clk); #1;
    chk({name, "_done"}, done, 1);
    chk({name, "_idle"}, busy, 0);
    @(posedge clk); #1;
    chk({name, "_done_off"}, done, 0);
`endif
  endtask

  initial forever begin
    if (tog) sig_ready = ~sig_ready;
    @(posedge clk); #1;
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      hold_v = 0;
      prev_done = 0;
    end else begin
      if (hold_v) chk("stall_hold", {sig_valid, sig_last, sig_data}, {1'b1, hold_l, hold_d});
      if (sig_valid && sig_ready) begin
        if (cnt_mode) begin
          cnt_words++;
          if (sig_last) last_at = cnt_words;
        end else if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h required=none", sig_data);
        end else begin
          e = q.pop_front();
          chk("stream_word", {sig_last, sig_data}, e);
        end
      end
      hold_v = sig_valid && !sig_ready;
      hold_d = sig_data;
      hold_l = sig_last;
      if (done) begin
        done_seen++;
        chk("done_pulse", prev_done, 0);
        if (!cnt_mode) chk("done_drained", q.size(), 0);
      end
      prev_done = done;
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h10000000 + i;
    mem[64] = A; mem[65] = B; mem[66] = C;
    mem[128] = 1; mem[129] = 2; mem[130] = 4;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", sig_valid, 0);
    chk("rst_last", sig_last, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_data", sig_data, 0);
    chk("rst_rd_addr", mem_rd_addr, 0);
    rst = 1;
    @(posedge clk); #1;
    cfg(32'h101, 32'h10E);
    push3(A, B, C, CS_ABC);
    store(HALT, 0);
    chk("rd_en_after_halt", mem_rd_en, 1);
    chk("rd_addr_aligned", mem_rd_addr, 32'h100);
    chk("busy_after_halt", busy, 1);
    @(posedge clk); #1;
    chk("wait_no_valid", sig_valid, 0);
    chk("wait_rd_en_off", mem_rd_en, 0);
    @(posedge clk); #1;
    chk("first_valid", sig_valid, 1);
    chk("first_data", sig_data, A);
    wait_done(40, "done_basic");
    sig_ready = 0;
    tog = 1;
    push3(A, B, C, CS_ABC);
    store(HALT, 0);
    wait_done(80, "done_toggle");
    tog = 0;
    sig_ready = 1;
    cfg(32'h100, 32'h100);
    empty_dump("eq_window");
    cfg(32'h10C, 32'h100);
    empty_dump("neg_window");
    cfg(32'h100, 32'h10C);
    push3(A, B, C, CS_ABC);
    store(HALT, 0);
    store(CFG, 32'h200);
    store(HALT, 0);
    store(CFG + 4, 32'h300);
    wait_done(40, "done_ignored");
    push3(A, B, C, CS_ABC);
    store(HALT, 0);
    wait_done(40, "done_cfg_kept");
    sig_ready = 0;
    store(HALT, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("valid_before_rst", sig_valid, 1);
    rst = 0;
    #1;
    chk("rst_mid_valid", sig_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    @(posedge clk); #1;
    rst = 1;
    sig_ready = 1;
    empty_dump("post_rst_cfg_zero");
    cfg(32'h100, 32'h10C);
    push3(A, B, C, CS_ABC);
    store(HALT, 0);
    wait_done(40, "done_restart");
    cfg(32'h200, 32'h20C);
    push3(1, 2, 4, 7);
    store(HALT, 0);
    wait_done(40, "done_124");
    cnt_mode = 1;
    cfg(32'h0, 32'h8000);
    store(HALT, 0);
    wait_done(20000, "done_cap");
    cnt_mode = 0;
    chk("cap_words", cnt_words, CAPW);
    chk("cap_last", last_at, CAPW);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
